// File: rtl/chunked_addsub.sv
// chunked_addsub: multi-cycle two's-complement adder/subtractor.
// Operands are consumed CHUNK bits per clock through a CHUNK-bit carry chain,
// with valid/ready handshakes on both input and output sides.
// Optional feature macro: CHUNKED_ADDSUB_SAT_EN (saturate result on signed overflow).
module chunked_addsub #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int IW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] opa_reg;
  logic [WIDTH-1:0] opb_reg;
  logic             carry_reg;
  logic [KW-1:0]    k_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carryout_reg;
  logic             overflow_reg;
  logic             zero_reg;

  // Per-cycle chunk datapath
  logic [IW-1:0]    chunk_base;
  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;
  logic [CHUNK:0]   chunk_sum;
  logic             chunk_cout;
  logic             msb_cin;
  logic             last_chunk;
  logic             ovf_now;
  logic [WIDTH-1:0] sum_wrapped;
  logic [WIDTH-1:0] sum_final;
  logic [N-1:0]     chunk_nonzero;
  logic             final_is_zero;

  // Select the active chunk and add it with the running carry
  always_comb begin
    chunk_base  = IW'(k_reg) * IW'(CHUNK);
    chunk_a     = opa_reg[chunk_base +: CHUNK];
    chunk_b     = opb_reg[chunk_base +: CHUNK];
    chunk_sum   = {1'b0, chunk_a} + {1'b0, chunk_b} + {{CHUNK{1'b0}}, carry_reg};
    chunk_cout  = chunk_sum[CHUNK];
    // Carry into the top bit of this chunk, recovered from its sum bit.
    msb_cin     = chunk_sum[CHUNK-1] ^ chunk_a[CHUNK-1] ^ chunk_b[CHUNK-1];
    last_chunk  = (k_reg == KW'(N - 1));
    ovf_now     = msb_cin ^ chunk_cout;
    // On the last chunk the lower chunks are already in sum_reg; splice in the top one.
    sum_wrapped = sum_reg;
    sum_wrapped[WIDTH-1 -: CHUNK] = chunk_sum[CHUNK-1:0];
  end

  // Final result: wrapped, or clamped toward the sign of opA on overflow
`ifdef CHUNKED_ADDSUB_SAT_EN
  always_comb begin
    sum_final = sum_wrapped;
    if (ovf_now) begin
      sum_final = {opa_reg[WIDTH-1], {(WIDTH-1){~opa_reg[WIDTH-1]}}};
    end
  end
`else
  assign sum_final = sum_wrapped;
`endif

  // Zero detect on the final value, reduced chunk by chunk
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_zero
      assign chunk_nonzero[gi] = |sum_final[gi*CHUNK +: CHUNK];
    end
  endgenerate
  assign final_is_zero = ~|chunk_nonzero;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = BUSY;
      BUSY:    if (last_chunk) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state
  always_comb begin
    in_ready  = (state_reg == IDLE);
    out_valid = (state_reg == DONE);
  end

  // Operand latch, chunk accumulation and flag capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      opa_reg      <= '0;
      opb_reg      <= '0;
      carry_reg    <= 1'b0;
      k_reg        <= '0;
      sum_reg      <= '0;
      carryout_reg <= 1'b0;
      overflow_reg <= 1'b0;
      zero_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            opa_reg   <= a;
            opb_reg   <= sub ? ~b : b;
            carry_reg <= sub;
            k_reg     <= '0;
          end
        end
        BUSY: begin
          carry_reg <= chunk_cout;
          if (last_chunk) begin
            sum_reg      <= sum_final;
            carryout_reg <= chunk_cout;
            overflow_reg <= ovf_now;
            zero_reg     <= final_is_zero;
            k_reg        <= '0;
          end else begin
            sum_reg[chunk_base +: CHUNK] <= chunk_sum[CHUNK-1:0];
            k_reg                        <= k_reg + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign sum      = sum_reg;
  assign carryout = carryout_reg;
  assign overflow = overflow_reg;
  assign zero     = zero_reg;

endmodule

// File: tb/tb_chunked_addsub.sv
// tb_chunked_addsub: directed vectors for chunked_addsub with a behavioural
// model and a per-cycle output checker. Model honours CHUNKED_ADDSUB_SAT_EN.
module tb_chunked_addsub;

  localparam int W  = 8;
  localparam int NC = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready, sub;
  logic [W-1:0] a, b, sum;
  logic         carryout, overflow, zero;

  logic         in_valid1, in_ready1, out_valid1, out_ready1, sub1;
  logic [W-1:0] a1, b1, sum1;
  logic         carryout1, overflow1, zero1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  chunked_addsub #(.WIDTH(W), .CHUNK(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carryout(carryout), .overflow(overflow), .zero(zero)
  );

  chunked_addsub #(.WIDTH(W), .CHUNK(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .sub(sub1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .carryout(carryout1), .overflow(overflow1), .zero(zero1)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  // Model: {sum[7:0], carryout, overflow, zero} from plain arithmetic
  function automatic logic [10:0] model(input logic [7:0] x, input logic [7:0] y, input logic s);
    logic [7:0] yy;
    logic [8:0] full;
    int         sx;
    logic [7:0] r;
    logic       v;
    yy   = s ? ~y : y;
    full = {1'b0, x} + {1'b0, yy} + {8'd0, s};
    sx   = s ? (int'($signed(x)) - int'($signed(y))) : (int'($signed(x)) + int'($signed(y)));
    v    = (sx > 127) || (sx < -128);
    r    = full[7:0];
`ifdef CHUNKED_ADDSUB_SAT_EN
    if (v) r = (sx > 127) ? 8'h7F : 8'h80;
`endif
    return {r, full[8], v, (r == 8'h00)};
  endfunction

  // Per-cycle checker for the main instance
  logic [10:0] exp_q[$];
  bit          started   = 0;
  bit          in_flight = 0;
  int          edges     = 0;

  always @(negedge clk) begin
    if (started) begin
      if (in_flight) begin
        check("mon out_valid timing", out_valid, (edges >= NC));
        check("mon in_ready busy", in_ready, 1'b0);
        if (out_valid && edges >= NC && exp_q.size() > 0) begin
          check("mon result", {sum, carryout, overflow, zero}, exp_q[0]);
        end
      end else begin
        check("mon idle out_valid", out_valid, 1'b0);
        check("mon idle in_ready", in_ready, 1'b1);
      end
    end
    if (!rst_n) begin
      started   = 1;
      in_flight = 0;
      exp_q.delete();
    end else if (started) begin
      if (in_flight) begin
        if (out_valid && out_ready) begin
          in_flight = 0;
          void'(exp_q.pop_front());
        end else begin
          edges++;
        end
      end else if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, sub));
        in_flight = 1;
        edges     = 0;
      end
    end
  end

  task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic s,
                        input logic [7:0] es, input logic ec, input logic ev, input logic ez,
                        input int hold, input bit toggle);
    int lat;
    a = x; b = y; sub = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (toggle) begin
        a = 8'($urandom); b = 8'($urandom); sub = ~sub;
      end
      @(posedge clk); #1;
      lat++;
    end
    check("done reached", out_valid, 1'b1);
    check("latency", lat, NC);
    check("sum", sum, es);
    check("flags", {carryout, overflow, zero}, {ec, ev, ez});
    $display("txn a=%02h b=%02h sub=%0d -> sum=%02h c=%0d v=%0d z=%0d lat=%0d",
             x, y, s, sum, carryout, overflow, zero, lat);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom);
      @(posedge clk); #1;
      check("hold out_valid", out_valid, 1'b1);
      check("hold in_ready", in_ready, 1'b0);
      check("hold sum", sum, es);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post in_ready", in_ready, 1'b1);
    check("post out_valid", out_valid, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0; sub1 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    check("reset in_ready", in_ready, 1'b1);
    check("reset out_valid", out_valid, 1'b0);
    check("reset sum", sum, 8'h00);
    check("reset flags", {carryout, overflow, zero}, 3'b000);
    check("reset in_ready chunk8", in_ready1, 1'b1);

    // Hand-computed pins on the model itself
    check("model 100+27", model(8'd100, 8'd27, 1'b0), {8'h7F, 3'b000});
    check("model 5-3", model(8'd5, 8'd3, 1'b1), {8'h02, 3'b100});
    check("model 4-4", model(8'd4, 8'd4, 1'b1), {8'h00, 3'b101});
    check("model 3-5", model(8'd3, 8'd5, 1'b1), {8'hFE, 3'b000});

    run_op(8'd100, 8'd27, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0, 0, 0);
`ifdef CHUNKED_ADDSUB_SAT_EN
    run_op(8'd100, 8'd28, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0, 0, 0);
    run_op(8'h80,  8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0, 0, 0);
`else
    run_op(8'd100, 8'd28, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 0, 0);
    run_op(8'h80,  8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0, 0, 0);
`endif
    run_op(8'd5, 8'd3, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 0, 0);
    run_op(8'd3, 8'd5, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0, 0, 0);
    run_op(8'd4, 8'd4, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 0, 0);
    // Stall in DONE and scramble inputs while BUSY
    run_op(8'h3C, 8'h15, 1'b0, 8'h51, 1'b0, 1'b0, 1'b0, 5, 1);

    // Abort at the second BUSY edge
    a = 8'd50; b = 8'd60; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    check("abort in_ready", in_ready, 1'b1);
    check("abort out_valid", out_valid, 1'b0);
    check("abort sum", sum, 8'h00);
    check("abort flags", {carryout, overflow, zero}, 3'b000);
    $display("txn abort a=32 b=3c sub=0 -> reset at second busy edge");
    repeat (6) @(posedge clk);
    #1;
    run_op(8'd1, 8'd1, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 0, 0);

`ifdef CHUNKED_ADDSUB_SAT_EN
    run_op(8'd127, 8'd1, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0, 0, 0);
    run_op(8'h80,  8'd1, 1'b1, 8'h80, 1'b1, 1'b1, 1'b0, 0, 0);
`else
    run_op(8'd127, 8'd1, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 0, 0);
    run_op(8'h80,  8'd1, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0, 0, 0);
`endif

    // Single-chunk instance: one BUSY cycle, same result
    a1 = 8'd100; b1 = 8'd27; sub1 = 1'b0; in_valid1 = 1'b1;
    @(posedge clk); #1 in_valid1 = 1'b0;
    check("chunk8 busy out_valid", out_valid1, 1'b0);
    @(posedge clk); #1;
    check("chunk8 latency out_valid", out_valid1, 1'b1);
    check("chunk8 sum", sum1, 8'h7F);
    check("chunk8 flags", {carryout1, overflow1, zero1}, 3'b000);
    $display("txn chunk8 a=64 b=1b sub=0 -> sum=%02h c=%0d v=%0d z=%0d",
             sum1, carryout1, overflow1, zero1);
    out_ready1 = 1'b1;
    @(posedge clk); #1 out_ready1 = 1'b0;
    check("chunk8 post in_ready", in_ready1, 1'b1);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
